store_buffer_pair: RTL and testbench
====================================

// Module: store_buffer_pair
// PURPOSE
//  Ping-pong pair of store buffers feeding the store-buffer controller. Producer fills the
//  inactive bank while the consumer drains the active bank. When the active bank is empty and
//  the fill bank is complete, the banks swap and a 1-cycle trigger tells the controller.
//  The controller uses trigger to retarget its load/choose selects.
// PARAMETERS
//  DATA_W  32  width of one buffer entry
//  DEPTH   8   entries per bank; power of 2, >=2
//  ID_W    8   width of the batch id counter
// PORTS
//  clk          in   1               system clock, rising edge
//  rst_n        in   1               asynchronous, active-low reset
//  fill_valid   in   1               producer has a word
//  fill_data    in   DATA_W          producer word
//  fill_ready   out  1               fill bank accepts a word this cycle
//  flush        in   1               pulse: close current partial batch
//  drain_valid  out  1               active bank holds an undrained word
//  drain_data   out  DATA_W          current word of the active bank
//  drain_ready  in   1               consumer accepts drain_data
//  active_bank  out  1               bank being drained (fill bank = ~active_bank)
//  trigger      out  1               registered 1-cycle pulse after each swap
//  batch_len    out  $clog2(DEPTH)+1 word count of the batch now in the active bank
//  batch_id     out  ID_W            swap counter, wraps modulo 2**ID_W
// BEHAVIOUR
//  State: mem[2][DEPTH]; wr_cnt (0..DEPTH) words in fill bank; rd_left (0..DEPTH) words left
//   in active bank; flush_pend; active_bank; batch_len; batch_id; trigger.
//  Reset (async on rst_n low): active_bank=0, wr_cnt=0, rd_left=0, batch_len=0, batch_id=0,
//   flush_pend=0, trigger=0. mem contents are not reset. Outputs: fill_ready=1, drain_valid=0.
//  swap (comb) = (rd_left==0) && (wr_cnt==DEPTH || (flush_pend||flush) && wr_cnt!=0).
//  fill_ready = (wr_cnt<DEPTH) && !swap.
//  Fill: on fill_valid&&fill_ready, mem[~active_bank][wr_cnt]<=fill_data and wr_cnt++.
//  drain_valid = (rd_left!=0). drain_data = mem[active_bank][batch_len-rd_left], comb from
//   regs. It holds stable while drain_valid && !drain_ready.
//  Drain: on drain_valid&&drain_ready, rd_left--. Words leave in the order written.
//  Swap edge: active_bank<=~active_bank, rd_left<=wr_cnt, batch_len<=wr_cnt, wr_cnt<=0,
//   batch_id<=batch_id+1 (wraps), flush_pend<=0, trigger<=1. Otherwise trigger<=0.
//  A swap and a drain handshake never occur in the same cycle (swap needs rd_left==0).
//  A swap and a fill write never occur in the same cycle (fill_ready is low on swap).
//  Flush:
//   - flush with wr_cnt==0 sets flush_pend. The swap happens once a word is written and
//     the active bank is empty.
//   - flush while swap is already true has no extra effect.
//  Latency: after the DEPTH-th fill write with rd_left==0, swap is high the next cycle.
//   trigger and drain_valid are high the cycle after that.
//  No overflow: writes are blocked at wr_cnt==DEPTH until the active bank drains.
//  No underflow: drain_valid is 0 at rd_left==0, and drain_ready is then ignored.
//  Reset mid-operation discards all queued words and in-flight batches immediately.
// TESTING
//  1 Assert rst_n=0 mid-traffic -> fill_ready=1, drain_valid=0, active_bank=0, trigger=0,
//    batch_id=0, all on the asynchronous edge.
//  2 Write 0x10..0x17 back-to-back, drain_ready=1.
//    -> fill_ready=0 after the 8th write; trigger is one pulse.
//    -> active_bank=1, batch_len=8, batch_id=1.
//    -> drain_data 0x10..0x17 in 8 consecutive cycles.
//  3 Refill bank 0 with 0x20..0x27 while draining bank 1.
//    -> no swap until the cycle after the last drain handshake.
//    -> exactly one trigger, then 0x20..0x27 come out.
//  4 Fill bank full, active bank holding words, drain_ready=0 for 5 cycles.
//    -> drain_data stable, fill_ready=0, no trigger.
//  5 Write 3 words 0xA0..0xA2, then pulse flush with the active bank empty.
//    -> swap, batch_len=3, exactly 3 words drained.
//    Flush at wr_cnt=0 -> no swap until 1 word is written, then batch_len=1.
//  6 ID_W=2, 5 full batches -> batch_id sequence 1,2,3,0,1.
//    Reset asserted mid-drain -> clean restart, first batch out is batch_id=1.

Source files
------------

// File: rtl/store_buffer_pair.sv
// Ping-pong pair of store buffers: the producer fills one bank while the consumer drains the
// other, and the banks swap (with a one-cycle trigger pulse) once the active bank is empty.
module store_buffer_pair #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 8,
  parameter int ID_W   = 8
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       fill_valid,
  input  logic [DATA_W-1:0]          fill_data,
  output logic                       fill_ready,
  input  logic                       flush,
  output logic                       drain_valid,
  output logic [DATA_W-1:0]          drain_data,
  input  logic                       drain_ready,
  output logic                       active_bank,
  output logic                       trigger,
  output logic [$clog2(DEPTH):0]     batch_len,
  output logic [ID_W-1:0]            batch_id
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [DATA_W-1:0] mem_q [2][DEPTH];

  logic [CW-1:0]   wr_cnt_q, wr_cnt_d;
  logic [CW-1:0]   rd_left_q, rd_left_d;
  logic [CW-1:0]   batch_len_q, batch_len_d;
  logic [ID_W-1:0] batch_id_q, batch_id_d;
  logic            active_bank_q, active_bank_d;
  logic            flush_pend_q, flush_pend_d;
  logic            trigger_q, trigger_d;

  logic            swap;
  logic            fill_fire;
  logic            drain_fire;
  logic [CW-1:0]   rd_idx;

  // Swap only with the active bank empty, so it never coincides with a drain handshake.
  assign swap = (rd_left_q == '0) &&
                ((wr_cnt_q == CW'(DEPTH)) || ((flush_pend_q || flush) && (wr_cnt_q != '0)));

  assign fill_ready  = (wr_cnt_q < CW'(DEPTH)) && !swap;
  assign fill_fire   = fill_valid && fill_ready;
  assign drain_valid = (rd_left_q != '0);
  assign drain_fire  = drain_valid && drain_ready;

  // Words leave in write order: offset into the batch is what has already been drained.
  assign rd_idx      = batch_len_q - rd_left_q;
  assign drain_data  = mem_q[active_bank_q][rd_idx[AW-1:0]];

  assign active_bank = active_bank_q;
  assign trigger     = trigger_q;
  assign batch_len   = batch_len_q;
  assign batch_id    = batch_id_q;

  always_comb begin
    wr_cnt_d      = wr_cnt_q;
    rd_left_d     = rd_left_q;
    batch_len_d   = batch_len_q;
    batch_id_d    = batch_id_q;
    active_bank_d = active_bank_q;
    flush_pend_d  = flush_pend_q;
    trigger_d     = 1'b0;

    if (fill_fire)  wr_cnt_d  = wr_cnt_q + CW'(1);
    if (drain_fire) rd_left_d = rd_left_q - CW'(1);

    if (swap) begin
      active_bank_d = ~active_bank_q;
      rd_left_d     = wr_cnt_q;
      batch_len_d   = wr_cnt_q;
      wr_cnt_d      = '0;
      batch_id_d    = batch_id_q + ID_W'(1);
      flush_pend_d  = 1'b0;
      trigger_d     = 1'b1;
    end else if (flush) begin
      // Remember the flush until there is a word to close and the active bank is free.
      flush_pend_d  = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_cnt_q      <= '0;
      rd_left_q     <= '0;
      batch_len_q   <= '0;
      batch_id_q    <= '0;
      active_bank_q <= 1'b0;
      flush_pend_q  <= 1'b0;
      trigger_q     <= 1'b0;
    end else begin
      wr_cnt_q      <= wr_cnt_d;
      rd_left_q     <= rd_left_d;
      batch_len_q   <= batch_len_d;
      batch_id_q    <= batch_id_d;
      active_bank_q <= active_bank_d;
      flush_pend_q  <= flush_pend_d;
      trigger_q     <= trigger_d;
    end
  end

  // Storage is deliberately not reset; the counters alone define which words are live.
  always_ff @(posedge clk) begin
    if (fill_fire) mem_q[~active_bank_q][wr_cnt_q[AW-1:0]] <= fill_data;
  end

endmodule

// File: tb/tb_store_buffer_pair.sv
// Bench for store_buffer_pair: vector table for the basic batch, hand sequences for the
// multi-cycle corners, and random traffic against a queue-level reference model.
module tb_store_buffer_pair;

  localparam int DATA_W = 32;
  localparam int DEPTH  = 8;
  localparam int ID_W   = 2;

  logic              clk;
  logic              rst_n;
  logic              fill_valid;
  logic [DATA_W-1:0] fill_data;
  logic              fill_ready;
  logic              flush;
  logic              drain_valid;
  logic [DATA_W-1:0] drain_data;
  logic              drain_ready;
  logic              active_bank;
  logic              trigger;
  logic [3:0]        batch_len;
  logic [ID_W-1:0]   batch_id;

  store_buffer_pair #(.DATA_W(DATA_W), .DEPTH(DEPTH), .ID_W(ID_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .fill_valid(fill_valid), .fill_data(fill_data), .fill_ready(fill_ready),
    .flush(flush),
    .drain_valid(drain_valid), .drain_data(drain_data), .drain_ready(drain_ready),
    .active_bank(active_bank), .trigger(trigger),
    .batch_len(batch_len), .batch_id(batch_id)
  );

  // Clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_checks = 0;
  int n_err    = 0;
  int trig_seen = 0;

  // Reference model: the fill bank and the active bank as plain queues of words.
  logic [DATA_W-1:0] m_fill[$];
  logic [DATA_W-1:0] m_act[$];
  bit m_pend, m_trig, m_bank;
  int m_blen, m_bid;

  task automatic model_reset();
    m_fill.delete();
    m_act.delete();
    m_pend = 0; m_trig = 0; m_bank = 0; m_blen = 0; m_bid = 0;
  endtask

  function automatic bit m_swap();
    return (m_act.size() == 0) &&
           ((m_fill.size() == DEPTH) || ((m_pend || flush) && m_fill.size() != 0));
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_check();
    bit sw;
    sw = m_swap();
    chk("fill_ready", 64'(fill_ready), 64'((m_fill.size() < DEPTH) && !sw));
    chk("drain_valid", 64'(drain_valid), 64'(m_act.size() != 0));
    if (m_act.size() != 0) chk("drain_data", 64'(drain_data), 64'(m_act[0]));
    chk("active_bank", 64'(active_bank), 64'(m_bank));
    chk("trigger", 64'(trigger), 64'(m_trig));
    chk("batch_len", 64'(batch_len), 64'(m_blen));
    chk("batch_id", 64'(batch_id), 64'(m_bid));
  endtask

  // Driver: apply inputs just after a rising edge, check the model mid-cycle.
  task automatic drive(input bit fv, input logic [DATA_W-1:0] fd, input bit fl, input bit dr);
    fill_valid = fv; fill_data = fd; flush = fl; drain_ready = dr;
    #3;
    if (trigger === 1'b1) trig_seen++;
    model_check();
  endtask

  // Advance the model by the rules of one clock edge, then the real clock.
  task automatic tick();
    bit sw, fr, dv;
    sw = m_swap();
    fr = (m_fill.size() < DEPTH) && !sw;
    dv = (m_act.size() != 0);
    if (dv && drain_ready) void'(m_act.pop_front());
    if (fill_valid && fr) m_fill.push_back(fill_data);
    if (sw) begin
      m_act  = m_fill;
      m_fill.delete();
      m_blen = m_act.size();
      m_bid  = (m_bid + 1) % (1 << ID_W);
      m_bank = ~m_bank;
      m_pend = 0;
      m_trig = 1;
    end else begin
      m_trig = 0;
      if (flush) m_pend = 1;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic cycle(input bit fv, input logic [DATA_W-1:0] fd, input bit fl, input bit dr);
    drive(fv, fd, fl, dr);
    tick();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    fill_valid = 0; fill_data = '0; flush = 0; drain_ready = 0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  typedef struct {
    bit fv; logic [DATA_W-1:0] fd; bit fl; bit dr;
    bit e_fr; bit e_dv; logic [DATA_W-1:0] e_dd; bit e_trig; bit e_bank;
    logic [ID_W-1:0] e_bid; logic [3:0] e_blen;
  } vec_t;

  vec_t tbl[18];
  logic [ID_W-1:0] bid_seq[5];

  initial begin
    // Hand-derived vectors: one full batch 0x10..0x17 written, swapped, drained.
    for (int k = 0; k < 8; k++)
      tbl[k] = '{1'b1, 32'h10 + 32'(k), 1'b0, 1'b1, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 2'd0, 4'd0};
    tbl[8] = '{1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 2'd0, 4'd0};
    for (int k = 0; k < 8; k++)
      tbl[9+k] = '{1'b0, 32'h0, 1'b0, 1'b1, 1'b1, 1'b1, 32'h10 + 32'(k), (k == 0), 1'b1, 2'd1, 4'd8};
    tbl[17] = '{1'b0, 32'h0, 1'b0, 1'b1, 1'b1, 1'b0, 32'h0, 1'b0, 1'b1, 2'd1, 4'd8};
    bid_seq[0] = 2'd1; bid_seq[1] = 2'd2; bid_seq[2] = 2'd3; bid_seq[3] = 2'd0; bid_seq[4] = 2'd1;

    do_reset();
    drive(0, 0, 0, 0);
    chk("reset_fill_ready", 64'(fill_ready), 64'd1);
    chk("reset_drain_valid", 64'(drain_valid), 64'd0);
    tick();

    // Table: basic batch
    for (int i = 0; i < 18; i++) begin
      drive(tbl[i].fv, tbl[i].fd, tbl[i].fl, tbl[i].dr);
      chk($sformatf("tbl%0d_fill_ready", i), 64'(fill_ready), 64'(tbl[i].e_fr));
      chk($sformatf("tbl%0d_drain_valid", i), 64'(drain_valid), 64'(tbl[i].e_dv));
      if (tbl[i].e_dv) chk($sformatf("tbl%0d_drain_data", i), 64'(drain_data), 64'(tbl[i].e_dd));
      chk($sformatf("tbl%0d_trigger", i), 64'(trigger), 64'(tbl[i].e_trig));
      chk($sformatf("tbl%0d_active_bank", i), 64'(active_bank), 64'(tbl[i].e_bank));
      chk($sformatf("tbl%0d_batch_id", i), 64'(batch_id), 64'(tbl[i].e_bid));
      if (i >= 9) chk($sformatf("tbl%0d_batch_len", i), 64'(batch_len), 64'(tbl[i].e_blen));
      tick();
    end

    // Refill the idle bank while the active one drains; swap waits for the last handshake.
    do_reset();
    trig_seen = 0;
    for (int k = 0; k < 8; k++) cycle(1, 32'h40 + 32'(k), 0, 0);
    cycle(0, 0, 0, 0);
    for (int k = 0; k < 8; k++) cycle(1, 32'h20 + 32'(k), 0, 1);
    cycle(0, 0, 0, 1);
    for (int k = 0; k < 9; k++) cycle(0, 0, 0, 1);
    chk("refill_trigger_count", 64'(trig_seen), 64'd2);

    // Stalled consumer with a full fill bank: nothing moves.
    do_reset();
    for (int k = 0; k < 8; k++) cycle(1, 32'h50 + 32'(k), 0, 0);
    cycle(0, 0, 0, 0);
    cycle(0, 0, 0, 1);
    cycle(0, 0, 0, 1);
    for (int k = 0; k < 8; k++) cycle(1, 32'h60 + 32'(k), 0, 0);
    trig_seen = 0;
    for (int k = 0; k < 5; k++) begin
      drive(1, 32'hdead, 0, 0);
      chk("stall_drain_data", 64'(drain_data), 64'h52);
      chk("stall_fill_ready", 64'(fill_ready), 64'd0);
      tick();
    end
    chk("stall_no_trigger", 64'(trig_seen), 64'd0);
    for (int k = 0; k < 20; k++) cycle(0, 0, 0, 1);

    // Flush of a partial batch, and flush on an empty fill bank.
    do_reset();
    for (int k = 0; k < 3; k++) cycle(1, 32'ha0 + 32'(k), 0, 0);
    cycle(0, 0, 1, 1);
    drive(0, 0, 0, 1);
    chk("flush_batch_len3", 64'(batch_len), 64'd3);
    chk("flush_trigger", 64'(trigger), 64'd1);
    tick();
    for (int k = 0; k < 3; k++) cycle(0, 0, 0, 1);
    drive(0, 0, 0, 1);
    chk("flush_drained_3", 64'(drain_valid), 64'd0);
    tick();
    cycle(0, 0, 1, 0);
    cycle(0, 0, 0, 0);
    cycle(0, 0, 0, 0);
    cycle(1, 32'hb0, 0, 0);
    cycle(0, 0, 0, 0);
    drive(0, 0, 0, 1);
    chk("flush_batch_len1", 64'(batch_len), 64'd1);
    chk("flush_pend_data", 64'(drain_data), 64'hb0);
    tick();
    cycle(0, 0, 0, 1);

    // Batch id wraps modulo 2**ID_W.
    do_reset();
    for (int b = 0; b < 5; b++) begin
      for (int k = 0; k < 8; k++) cycle(1, 32'(b * 16 + k), 0, 0);
      cycle(0, 0, 0, 0);
      drive(0, 0, 0, 1);
      chk($sformatf("bid_seq%0d", b), 64'(batch_id), 64'(bid_seq[b]));
      tick();
      for (int k = 0; k < 7; k++) cycle(0, 0, 0, 1);
    end
    // Reset in the middle of a drain restarts cleanly.
    for (int k = 0; k < 8; k++) cycle(1, 32'h70 + 32'(k), 0, 0);
    cycle(0, 0, 0, 0);
    cycle(0, 0, 0, 1);
    cycle(0, 0, 0, 1);
    do_reset();
    for (int k = 0; k < 8; k++) cycle(1, 32'h80 + 32'(k), 0, 0);
    cycle(0, 0, 0, 0);
    drive(0, 0, 0, 1);
    chk("restart_batch_id", 64'(batch_id), 64'd1);
    chk("restart_first_word", 64'(drain_data), 64'h80);
    tick();

    // Random traffic against the model.
    for (int i = 0; i < 800; i++)
      cycle(1'($urandom_range(0, 1)), $urandom, ($urandom_range(0, 15) == 0),
            1'($urandom_range(0, 3) != 0));

    // Asynchronous reset mid-traffic, checked before any clock edge.
    for (int k = 0; k < 8; k++) cycle(1, 32'h90 + 32'(k), 0, 0);
    cycle(0, 0, 0, 0);
    fill_valid = 1; drain_ready = 0; flush = 0;
    rst_n = 1'b0;
    #1;
    chk("async_fill_ready", 64'(fill_ready), 64'd1);
    chk("async_drain_valid", 64'(drain_valid), 64'd0);
    chk("async_active_bank", 64'(active_bank), 64'd0);
    chk("async_trigger", 64'(trigger), 64'd0);
    chk("async_batch_id", 64'(batch_id), 64'd0);
    do_reset();
    for (int k = 0; k < 10; k++) cycle(1'($urandom_range(0, 1)), $urandom, 0, 1);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
